// File: rtl/b07_trace_pkg.sv
// Shared types and default widths for the b07 trace recorder.
//   trace_entry_t : one recorded change {data, stamp} at default widths
//   rec_state_t   : recorder window state
package b07_trace_pkg;

  localparam int unsigned DEF_DATA_W  = 8;
  localparam int unsigned DEF_STAMP_W = 16;
  localparam int unsigned DEF_DEPTH   = 16;

  typedef struct packed {
    logic [DEF_DATA_W-1:0]  data;
    logic [DEF_STAMP_W-1:0] stamp;
  } trace_entry_t;

  typedef enum logic {
    IDLE    = 1'b0,
    CAPTURE = 1'b1
  } rec_state_t;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous show-ahead FIFO of trace entries.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   push/wr_entry: write request (taken if not full, or if a pop happens too)
//   pop          : remove head entry (ignored when empty)
//   flush        : discard all entries
//   rd_entry     : head entry, zero when empty
//   full, empty, count : occupancy
module trace_fifo
  import b07_trace_pkg::*;
#(
  parameter type         ENTRY_T = trace_entry_t,
  parameter int unsigned DEPTH   = DEF_DEPTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  ENTRY_T                   wr_entry,
  output ENTRY_T                   rd_entry,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  ENTRY_T      mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  // Extra MSB on each pointer tells full (MSBs differ) from empty (equal).
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && !flush && do_push) mem[wr_ptr[AW-1:0]] <= wr_entry;
  end

  assign rd_entry = empty ? ENTRY_T'('0) : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/b07_trace_recorder.sv
// Response recorder: during a capture window, stores each change of the
// sampled bus with a saturating cycle stamp into a show-ahead FIFO.
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   arm / stop            : start (or restart) / end the capture window
//   sample, sample_en     : observed bus value and its qualifier
//   rd_valid/rd_data/rd_stamp/rd_ready : valid/ready read port of the FIFO head
//   capturing             : window open
//   overflow              : sticky, a change was dropped on a full FIFO
//   count                 : entries held
module b07_trace_recorder
  import b07_trace_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned DEPTH   = DEF_DEPTH,
  parameter int unsigned STAMP_W = DEF_STAMP_W
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       arm,
  input  logic                       stop,
  input  logic [DATA_W-1:0]          sample,
  input  logic                       sample_en,
  output logic                       rd_valid,
  output logic [DATA_W-1:0]          rd_data,
  output logic [STAMP_W-1:0]         rd_stamp,
  input  logic                       rd_ready,
  output logic                       capturing,
  output logic                       overflow,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic [STAMP_W-1:0] stamp;
  } entry_t;

  localparam logic [STAMP_W-1:0] STAMP_MAX = '1;

  rec_state_t          state_q;
  rec_state_t          state_d;
  logic                clear;
  logic                rec_window;
  logic [STAMP_W-1:0]  stamp_q;
  logic [DATA_W-1:0]   last_q;
  logic                have_last_q;
  logic                candidate;
  logic                pop;
  logic                full;
  logic                empty;
  logic                push_ok;
  entry_t              wr_entry;
  entry_t              rd_entry;

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // arm takes priority over stop; the arm and stop cycles never record.
  always_comb begin
    state_d    = state_q;
    clear      = 1'b0;
    rec_window = 1'b0;
    case (state_q)
      IDLE: begin
        if (arm) begin
          state_d = CAPTURE;
          clear   = 1'b1;
        end
      end
      CAPTURE: begin
        if (arm)       clear   = 1'b1;
        else if (stop) state_d = IDLE;
        else           rec_window = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign capturing = (state_q == CAPTURE);
  assign rd_valid  = ~empty;
  assign pop       = rd_valid & rd_ready;
  assign candidate = rec_window & sample_en & (~have_last_q | (sample != last_q));
  assign push_ok   = candidate & (~full | pop);
  assign wr_entry  = '{data: sample, stamp: stamp_q};
  assign rd_data   = rd_entry.data;
  assign rd_stamp  = rd_entry.stamp;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      stamp_q     <= '0;
      have_last_q <= 1'b0;
      last_q      <= '0;
      overflow    <= 1'b0;
    end else begin
      if (rec_window && stamp_q != STAMP_MAX) stamp_q <= stamp_q + 1'b1;
      // last tracks every change, even dropped ones, so none is reported twice
      if (candidate) begin
        last_q      <= sample;
        have_last_q <= 1'b1;
      end
      if (candidate && !push_ok) overflow <= 1'b1;
    end
  end

  trace_fifo #(
    .ENTRY_T (entry_t),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push_ok),
    .pop      (pop),
    .flush    (clear),
    .wr_entry (wr_entry),
    .rd_entry (rd_entry),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );

endmodule
